exers: RTL

//   Execute reservation station. Sits directly downstream of the rename/dispatch stage.

---
 rtl/exers.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/exers.sv
// Execute reservation station: buffers dispatched micro-ops, captures operands from the
// writeback broadcast by tag, and issues one ready op per cycle. Define EXERS_AGE_ORDER_EN for oldest-first select.
module exers #(
  parameter int DEPTH = 8,
  parameter int TAGW  = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rename_exers_write,
  input  logic [4:0]      rename_op,
  input  logic [TAGW-1:0] rename_robid,
  input  logic [5:0]      rename_rd,
  input  logic            rename_op1ready,
  input  logic [31:0]     rename_op1,
  input  logic            rename_op2ready,
  input  logic [31:0]     rename_op2,
  output logic            exers_stall,
  input  logic            wb_valid,
  input  logic [TAGW-1:0] wb_robid,
  input  logic [31:0]     wb_result,
  output logic            exers_issue_valid,
  output logic [4:0]      exers_issue_op,
  output logic [TAGW-1:0] exers_issue_robid,
  output logic [5:0]      exers_issue_rd,
  output logic [31:0]     exers_issue_op1,
  output logic [31:0]     exers_issue_op2,
  input  logic            alu_stall,
  input  logic            rob_flush
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_rdy1;
  logic [DEPTH-1:0] r_rdy2;
  logic [4:0]       r_op    [DEPTH];
  logic [TAGW-1:0]  r_robid [DEPTH];
  logic [5:0]       r_rd    [DEPTH];
  logic [31:0]      r_val1  [DEPTH];
  logic [31:0]      r_val2  [DEPTH];

  logic             r_issue_valid;
  logic [4:0]       r_issue_op;
  logic [TAGW-1:0]  r_issue_robid;
  logic [5:0]       r_issue_rd;
  logic [31:0]      r_issue_op1;
  logic [31:0]      r_issue_op2;

  logic             w_clear;
  logic             w_wr_en;
  logic [IW-1:0]    w_free_idx;
  logic [DEPTH-1:0] w_wake1;
  logic [DEPTH-1:0] w_wake2;
  logic [DEPTH-1:0] w_cand;
  logic             w_sel_any;
  logic [IW-1:0]    w_sel_idx;
  logic             w_issue_load;
  logic             w_byp1;
  logic             w_byp2;
  logic             w_in_rdy1;
  logic             w_in_rdy2;
  logic [31:0]      w_in_val1;
  logic [31:0]      w_in_val2;

  assign w_clear     = rst | rob_flush;
  assign exers_stall = &r_valid;
  assign w_wr_en     = rename_exers_write & ~exers_stall & ~w_clear;

  // An operand broadcast in the same cycle it is dispatched is captured here, not lost.
  assign w_byp1    = ~rename_op1ready & wb_valid & (rename_op1[TAGW-1:0] == wb_robid);
  assign w_byp2    = ~rename_op2ready & wb_valid & (rename_op2[TAGW-1:0] == wb_robid);
  assign w_in_rdy1 = rename_op1ready | w_byp1;
  assign w_in_rdy2 = rename_op2ready | w_byp2;
  assign w_in_val1 = w_byp1 ? wb_result : rename_op1;
  assign w_in_val2 = w_byp2 ? wb_result : rename_op2;

  assign w_cand = r_valid & r_rdy1 & r_rdy2;

  // Lowest-index free entry and per-entry wakeup matches
  always_comb begin
    w_free_idx = {IW{1'b0}};
    w_wake1    = {DEPTH{1'b0}};
    w_wake2    = {DEPTH{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_free_idx = r_valid[i] ? w_free_idx : IW'(i);
      w_wake1[i] = r_valid[i] & ~r_rdy1[i] & wb_valid & (r_val1[i][TAGW-1:0] == wb_robid);
      w_wake2[i] = r_valid[i] & ~r_rdy2[i] & wb_valid & (r_val2[i][TAGW-1:0] == wb_robid);
    end
  end

`ifdef EXERS_AGE_ORDER_EN
  logic [IW:0] r_age [DEPTH];
  logic [IW:0] r_age_cnt;
  logic [IW:0] w_best_age;

  // Stamps live modulo 2*DEPTH; a is older than b when a-b wraps negative.
  function automatic logic age_older(input logic [IW:0] a, input logic [IW:0] b);
    logic [IW:0] diff;
    diff = a - b;
    return diff[IW];
  endfunction

  // Oldest ready entry wins the issue slot
  always_comb begin
    w_sel_any  = 1'b0;
    w_sel_idx  = {IW{1'b0}};
    w_best_age = {(IW+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (w_cand[i] && (!w_sel_any || age_older(r_age[i], w_best_age))) begin
        w_sel_idx  = IW'(i);
        w_best_age = r_age[i];
      end else begin
        w_best_age = w_best_age;
      end
      w_sel_any = w_sel_any | w_cand[i];
    end
  end

  // Dispatch counter and per-entry age stamps
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_age_cnt <= {(IW+1){1'b0}};
    end else if (w_wr_en) begin
      r_age_cnt            <= r_age_cnt + {{IW{1'b0}}, 1'b1};
      r_age[w_free_idx]    <= r_age_cnt;
    end else begin
      r_age_cnt <= r_age_cnt;
    end
  end
`else
  // Lowest-index ready entry wins the issue slot
  always_comb begin
    w_sel_any = 1'b0;
    w_sel_idx = {IW{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_sel_idx = w_cand[i] ? IW'(i) : w_sel_idx;
      w_sel_any = w_sel_any | w_cand[i];
    end
  end
`endif

  assign w_issue_load = ~w_clear & w_sel_any & (~r_issue_valid | ~alu_stall);

  // Entry array: dispatch fill, operand wakeup, and release on issue
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_valid <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_en && (w_free_idx == IW'(i))) begin
          r_valid[i] <= 1'b1;
          r_op[i]    <= rename_op;
          r_robid[i] <= rename_robid;
          r_rd[i]    <= rename_rd;
          r_rdy1[i]  <= w_in_rdy1;
          r_val1[i]  <= w_in_val1;
          r_rdy2[i]  <= w_in_rdy2;
          r_val2[i]  <= w_in_val2;
        end else begin
          if (w_wake1[i]) begin
            r_rdy1[i] <= 1'b1;
            r_val1[i] <= wb_result;
          end
          if (w_wake2[i]) begin
            r_rdy2[i] <= 1'b1;
            r_val2[i] <= wb_result;
          end
          if (w_issue_load && (w_sel_idx == IW'(i))) begin
            r_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Registered issue slot; holds while the execute unit stalls
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_issue_valid <= 1'b0;
      r_issue_op    <= 5'd0;
      r_issue_robid <= {TAGW{1'b0}};
      r_issue_rd    <= 6'd0;
      r_issue_op1   <= 32'd0;
      r_issue_op2   <= 32'd0;
    end else if (w_issue_load) begin
      r_issue_valid <= 1'b1;
      r_issue_op    <= r_op[w_sel_idx];
      r_issue_robid <= r_robid[w_sel_idx];
      r_issue_rd    <= r_rd[w_sel_idx];
      r_issue_op1   <= r_val1[w_sel_idx];
      r_issue_op2   <= r_val2[w_sel_idx];
    end else if (!alu_stall) begin
      r_issue_valid <= 1'b0;
    end else begin
      r_issue_valid <= r_issue_valid;
    end
  end

  assign exers_issue_valid = r_issue_valid;
  assign exers_issue_op    = r_issue_op;
  assign exers_issue_robid = r_issue_robid;
  assign exers_issue_rd    = r_issue_rd;
  assign exers_issue_op1   = r_issue_op1;
  assign exers_issue_op2   = r_issue_op2;

endmodule
